// File: rtl/signature_rx_if.sv
// signature_rx_if -- byte handoff between signature_rx and its consumer.
//
// Signals:
//   byte_out   [7:0]  assembled byte, stable while byte_valid is high
//   byte_valid        byte_out holds a byte the consumer has not yet taken
//   byte_ready        consumer takes byte_out on any cycle where both are high
//
// Modports:
//   master  the receiver (drives byte_out/byte_valid, observes byte_ready)
//   slave   the consumer (observes byte_out/byte_valid, drives byte_ready)
interface signature_rx_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_out,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/signature_rx.sv
// signature_rx -- serial-to-byte receiver with frame tracking and an optional
// built-in signature comparator.
//
// Bits arrive MSB-first on d, qualified by en. Every eighth bit completes a
// byte that is offered on a one-deep holding register (bus.byte_out /
// bus.byte_valid, taken when bus.byte_ready is high). When the holding
// register is still occupied and not being taken, the new byte is dropped
// and the sticky overrun flag is raised. byte_index counts completed bytes
// in the current frame (dropped ones included) and wraps after FRAME_BYTES,
// pulsing frame_done on the wrap.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   ld            synchronous frame restart, takes priority over en
//   en            bit strobe
//   d             serial data, MSB of each byte first
//   bus           signature_rx_if.master (byte_out, byte_valid, byte_ready)
//   byte_index    bytes completed in the current frame
//   frame_done    one-cycle pulse when the last byte of a frame completes
//   overrun       sticky, a completed byte was dropped (cleared by ld/reset)
//   match         frame equals the expected signature (check build only)
//   mismatch_cnt  mismatching bytes in the frame (check build only)
//
// Configuration:
//   SIG_RX_CHECK_EN  when defined, a 40-byte signature ROM is compared
//                    against each completed byte. FRAME_BYTES must be left
//                    at 40 in that build. When undefined, match and
//                    mismatch_cnt are tied to zero.
module signature_rx #(
  parameter int FRAME_BYTES = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld,
  input  logic                 en,
  input  logic                 d,
  signature_rx_if.master       bus,
  output logic [5:0]           byte_index,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 match,
  output logic [5:0]           mismatch_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);

  state_e     state_q,      state_d;
  logic [2:0] bit_cnt_q,    bit_cnt_d;
  logic [7:0] shift_q,      shift_d;
  logic [7:0] byte_out_q,   byte_out_d;
  logic       byte_valid_q, byte_valid_d;
  logic [5:0] byte_index_q, byte_index_d;
  logic       frame_done_q, frame_done_d;
  logic       overrun_q,    overrun_d;
  logic [7:0] new_byte_s;

`ifdef SIG_RX_CHECK_EN
  logic [5:0] mm_cnt_q, mm_cnt_d;
  logic [5:0] mm_base_s;
  logic       match_q,  match_d;

  // Expected signature: "Luke Vassallo Tiny Tapeout 2023/03/24.\r\n"
  function automatic logic [7:0] sig_rom_byte(input logic [5:0] idx);
    logic [7:0] val;
    case (idx)
      6'd0:    val = 8'h4C;
      6'd1:    val = 8'h75;
      6'd2:    val = 8'h6B;
      6'd3:    val = 8'h65;
      6'd4:    val = 8'h20;
      6'd5:    val = 8'h56;
      6'd6:    val = 8'h61;
      6'd7:    val = 8'h73;
      6'd8:    val = 8'h73;
      6'd9:    val = 8'h61;
      6'd10:   val = 8'h6C;
      6'd11:   val = 8'h6C;
      6'd12:   val = 8'h6F;
      6'd13:   val = 8'h20;
      6'd14:   val = 8'h54;
      6'd15:   val = 8'h69;
      6'd16:   val = 8'h6E;
      6'd17:   val = 8'h79;
      6'd18:   val = 8'h20;
      6'd19:   val = 8'h54;
      6'd20:   val = 8'h61;
      6'd21:   val = 8'h70;
      6'd22:   val = 8'h65;
      6'd23:   val = 8'h6F;
      6'd24:   val = 8'h75;
      6'd25:   val = 8'h74;
      6'd26:   val = 8'h20;
      6'd27:   val = 8'h32;
      6'd28:   val = 8'h30;
      6'd29:   val = 8'h32;
      6'd30:   val = 8'h33;
      6'd31:   val = 8'h2F;
      6'd32:   val = 8'h30;
      6'd33:   val = 8'h33;
      6'd34:   val = 8'h2F;
      6'd35:   val = 8'h32;
      6'd36:   val = 8'h34;
      6'd37:   val = 8'h2E;
      6'd38:   val = 8'h0D;
      6'd39:   val = 8'h0A;
      default: val = 8'h00;
    endcase
    return val;
  endfunction
`endif

  // The byte completed by the current bit, should this be the eighth one.
  assign new_byte_s = {shift_q[6:0], d};

  // Next-state logic: FSM, bit assembly, holding register, frame tracking.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    byte_index_d = byte_index_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
`ifdef SIG_RX_CHECK_EN
    mm_cnt_d     = mm_cnt_q;
    mm_base_s    = mm_cnt_q;
    match_d      = 1'b0;
`endif

    if (ld) begin
      // Restart wins over a same-cycle bit; byte_out keeps its last value.
      state_d      = ST_IDLE;
      bit_cnt_d    = 3'd0;
      shift_d      = 8'h00;
      byte_valid_d = 1'b0;
      byte_index_d = 6'd0;
      overrun_d    = 1'b0;
`ifdef SIG_RX_CHECK_EN
      mm_cnt_d     = 6'd0;
`endif
    end else begin
      // A pending byte taken this cycle frees the holding register.
      if (byte_valid_q && bus.byte_ready) begin
        byte_valid_d = 1'b0;
      end else begin
        byte_valid_d = byte_valid_q;
      end

      if (en) begin
        shift_d   = new_byte_s;
        bit_cnt_d = bit_cnt_q + 3'd1;

        case (state_q)
          ST_IDLE: state_d = ST_RECV;
          ST_RECV: state_d = ST_RECV;
          ST_DONE: begin
            // The previous frame's result is released on the first new bit.
            state_d = ST_RECV;
`ifdef SIG_RX_CHECK_EN
            mm_base_s = 6'd0;
            mm_cnt_d  = 6'd0;
`endif
          end
          default: state_d = ST_IDLE;
        endcase

        if (bit_cnt_q == 3'd7) begin
          // Load when empty or being emptied at this same edge, else drop.
          if (!byte_valid_q || bus.byte_ready) begin
            byte_out_d   = new_byte_s;
            byte_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end

          if (byte_index_q == LAST_IDX) begin
            byte_index_d = 6'd0;
            frame_done_d = 1'b1;
            state_d      = ST_DONE;
          end else begin
            byte_index_d = byte_index_q + 6'd1;
          end

`ifdef SIG_RX_CHECK_EN
          // Dropped bytes are still compared: the check is on the stream.
          if (new_byte_s != sig_rom_byte(byte_index_q)) begin
            mm_cnt_d = mm_base_s + 6'd1;
          end else begin
            mm_cnt_d = mm_base_s;
          end
`endif
        end else begin
          byte_index_d = byte_index_q;
        end
      end else begin
        state_d = state_q;
      end
    end

`ifdef SIG_RX_CHECK_EN
    match_d = (state_d == ST_DONE) && (mm_cnt_d == 6'd0);
`endif
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      byte_index_q <= 6'd0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIG_RX_CHECK_EN
      mm_cnt_q     <= 6'd0;
      match_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_index_q <= byte_index_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
`ifdef SIG_RX_CHECK_EN
      mm_cnt_q     <= mm_cnt_d;
      match_q      <= match_d;
`endif
    end
  end

  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign byte_index     = byte_index_q;
  assign frame_done     = frame_done_q;
  assign overrun        = overrun_q;

`ifdef SIG_RX_CHECK_EN
  assign match          = match_q;
  assign mismatch_cnt   = mm_cnt_q;
`else
  assign match          = 1'b0;
  assign mismatch_cnt   = 6'd0;
`endif

endmodule

// File: tb/tb_signature_rx.sv
// tb_signature_rx -- scoreboard bench for signature_rx.
// Bytes expected on the handoff are queued as they are sent and popped by a
// monitor whenever a transfer (byte_valid & byte_ready) occurs.
module tb_signature_rx;

  logic clk;
  logic reset;
  logic ld;
  logic en;
  logic d;
  logic [5:0] byte_index;
  logic frame_done;
  logic overrun;
  logic match;
  logic [5:0] mismatch_cnt;

  signature_rx_if bif ();

  signature_rx #(.FRAME_BYTES(40)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld           (ld),
    .en           (en),
    .d            (d),
    .bus          (bif),
    .byte_index   (byte_index),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .match        (match),
    .mismatch_cnt (mismatch_cnt)
  );

`ifdef SIG_RX_CHECK_EN
  localparam logic [31:0] EXP_MATCH_GOOD = 32'd1;
  localparam logic [31:0] EXP_MM_BAD     = 32'd1;
`else
  localparam logic [31:0] EXP_MATCH_GOOD = 32'd0;
  localparam logic [31:0] EXP_MM_BAD     = 32'd0;
`endif

  logic [7:0] sig [40] = '{
    8'h4C, 8'h75, 8'h6B, 8'h65, 8'h20, 8'h56, 8'h61, 8'h73, 8'h73, 8'h61,
    8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h54, 8'h69, 8'h6E, 8'h79, 8'h20, 8'h54,
    8'h61, 8'h70, 8'h65, 8'h6F, 8'h75, 8'h74, 8'h20, 8'h32, 8'h30, 8'h32,
    8'h33, 8'h2F, 8'h30, 8'h33, 8'h2F, 8'h32, 8'h34, 8'h2E, 8'h0D, 8'h0A
  };

  logic [7:0] exp_q [$];
  int tests_run = 0;
  int tests_failed = 0;
  int fd_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare every transferred byte against the scoreboard.
  always @(negedge clk) begin
    if (!reset && bif.byte_valid && bif.byte_ready) begin
      if (exp_q.size() == 0) begin
        chk_eq("sb_unexpected_byte", {24'd0, bif.byte_out}, 32'hFFFF_FFFF);
      end else begin
        chk_eq("sb_byte", {24'd0, bif.byte_out}, {24'd0, exp_q.pop_front()});
      end
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    d  = b;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit push);
    if (push) exp_q.push_back(v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pulse_ld();
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_byte_out"},   {24'd0, bif.byte_out}, 32'h00);
    chk_eq({tag, "_valid"},      {31'd0, bif.byte_valid}, 32'd0);
    chk_eq({tag, "_index"},      {26'd0, byte_index}, 32'd0);
    chk_eq({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk_eq({tag, "_overrun"},    {31'd0, overrun}, 32'd0);
    chk_eq({tag, "_mismatch"},   {26'd0, mismatch_cnt}, 32'd0);
    chk_eq({tag, "_match"},      {31'd0, match}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    ld = 1'b0;
    en = 1'b0;
    d = 1'b0;
    bif.byte_ready = 1'b0;
    #1;
    chk_reset_outputs("rst");
    tick();
    tick();
    reset = 1'b0;

    // Single byte with the consumer ready.
    bif.byte_ready = 1'b1;
    send_byte(8'h4C, 1'b1);
    chk_eq("b0_valid", {31'd0, bif.byte_valid}, 32'd1);
    chk_eq("b0_out",   {24'd0, bif.byte_out}, 32'h4C);
    chk_eq("b0_index", {26'd0, byte_index}, 32'd1);
    tick();
    chk_eq("b0_valid_drop", {31'd0, bif.byte_valid}, 32'd0);
    pulse_ld();
    chk_eq("ld_index", {26'd0, byte_index}, 32'd0);

    // Consumer stalled: second byte is dropped.
    bif.byte_ready = 1'b0;
    send_byte(8'h4C, 1'b0);
    send_byte(8'h75, 1'b0);
    chk_eq("ovr_out",     {24'd0, bif.byte_out}, 32'h4C);
    chk_eq("ovr_valid",   {31'd0, bif.byte_valid}, 32'd1);
    chk_eq("ovr_flag",    {31'd0, overrun}, 32'd1);
    chk_eq("ovr_index",   {26'd0, byte_index}, 32'd2);
    tick();
    chk_eq("ovr_sticky",  {31'd0, overrun}, 32'd1);
    pulse_ld();
    chk_eq("ovr_ld_flag",  {31'd0, overrun}, 32'd0);
    chk_eq("ovr_ld_valid", {31'd0, bif.byte_valid}, 32'd0);
    bif.byte_ready = 1'b1;

    // ld together with en after 3 bits: that bit is discarded.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    ld = 1'b1;
    en = 1'b1;
    d = 1'b1;
    tick();
    ld = 1'b0;
    en = 1'b0;
    chk_eq("ldmix_index0", {26'd0, byte_index}, 32'd0);
    send_byte(8'h4C, 1'b1);
    chk_eq("ldmix_out",   {24'd0, bif.byte_out}, 32'h4C);
    chk_eq("ldmix_index", {26'd0, byte_index}, 32'd1);
    pulse_ld();

    // Full signature frame.
    fd_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      send_byte(sig[i], 1'b1);
      if (i == 38) chk_eq("frm_no_early_done", {31'd0, frame_done}, 32'd0);
    end
    chk_eq("frm_done",     {31'd0, frame_done}, 32'd1);
    chk_eq("frm_index",    {26'd0, byte_index}, 32'd0);
    chk_eq("frm_match",    {31'd0, match}, EXP_MATCH_GOOD);
    chk_eq("frm_mismatch", {26'd0, mismatch_cnt}, 32'd0);
    tick();
    chk_eq("frm_done_pulse", {31'd0, frame_done}, 32'd0);
    chk_eq("frm_match_hold", {31'd0, match}, EXP_MATCH_GOOD);
    chk_eq("frm_done_count", fd_cnt, 32'd1);

    // Same frame with byte 5 corrupted.
    for (int i = 0; i < 40; i++) begin
      send_byte((i == 5) ? 8'h21 : sig[i], 1'b1);
      if (i == 0) begin
        chk_eq("bad_mm_cleared", {26'd0, mismatch_cnt}, 32'd0);
        chk_eq("bad_match_drop", {31'd0, match}, 32'd0);
      end
    end
    chk_eq("bad_done",     {31'd0, frame_done}, 32'd1);
    chk_eq("bad_match",    {31'd0, match}, 32'd0);
    chk_eq("bad_mismatch", {26'd0, mismatch_cnt}, EXP_MM_BAD);
    tick();
    pulse_ld();

    // Reset in the middle of byte 2.
    send_byte(sig[0], 1'b1);
    send_byte(sig[1], 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    tick();
    reset = 1'b0;
    send_byte(8'h4C, 1'b1);
    chk_eq("midrst_index", {26'd0, byte_index}, 32'd1);
    chk_eq("midrst_out",   {24'd0, bif.byte_out}, 32'h4C);
    tick();
    tick();
    chk_eq("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/signature_rx.md
SIGNATURE_RX -- requirements
Module: signature_rx

Interface
REQ-001 SHALL provide parameter FRAME_BYTES, default 40, bytes per frame (legal range 1..63).
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port ld  input  1  synchronous frame restart: realign to bit 0 of byte 0.
REQ-005 SHALL provide port en  input  1  bit strobe; d sampled on clk edge when en=1.
REQ-006 SHALL provide port d  input  1  serial data, MSB of each byte first.
REQ-007 SHALL provide port byte_out  output  8  assembled byte, held stable while byte_valid=1.
REQ-008 SHALL provide port byte_valid  output  1  byte_out holds an unconsumed byte.
REQ-009 SHALL provide port byte_ready  input  1  consumer accepts byte_out this cycle.
REQ-010 SHALL provide port byte_index  output  6  number of bytes completed in current frame.
REQ-011 SHALL provide port frame_done  output  1  one-cycle pulse when the last byte of a frame completes.
REQ-012 SHALL provide port overrun  output  1  sticky: a completed byte was dropped.
REQ-013 SHALL provide port match  output  1  frame equals expected signature (check build only).
REQ-014 SHALL provide port mismatch_cnt  output  6  count of mismatching bytes in frame (check build only).

Function
REQ-015 SHALL shift d into an 8-bit shift register on each en=1 cycle; a 3-bit bit counter 0..7 SHALL track position.
REQ-016 SHALL, on the 8th en bit, present the completed byte {shift[6:0],d} on byte_out with byte_valid=1 on the next cycle (1-cycle latency).
REQ-017 SHALL complete a transfer on any cycle with byte_valid=1 and byte_ready=1; byte_valid SHALL drop the following cycle unless a new byte loads at the same edge.
REQ-018 SHALL load a new byte when the holding register is empty or is transferred in the same cycle; otherwise SHALL drop the byte, keep the old byte_out, and set overrun.
REQ-019 SHALL increment byte_index per completed byte (dropped bytes included), wrapping from FRAME_BYTES-1 to 0 with frame_done=1 for that cycle.
REQ-020 SHALL implement FSM IDLE->RECV on first en; RECV->DONE at frame completion; DONE->RECV on next en; any state->IDLE on ld.
REQ-021 SHALL give ld priority over en: same-cycle bit discarded; bit counter, byte_index, shift register, overrun, mismatch_cnt cleared; byte_valid cleared.
REQ-022 SHALL hold overrun at 1 until ld or reset.
REQ-023 SHALL keep match/mismatch_cnt of the last frame while in DONE and clear mismatch_cnt on the first en in DONE.

Reset
REQ-024 SHALL on reset force: FSM IDLE, bit counter 0, byte_index 0, byte_out 0x00, byte_valid 0, frame_done 0, overrun 0, mismatch_cnt 0, match 0.
REQ-025 SHALL abandon any partial byte on reset mid-frame; no byte SHALL be emitted from pre-reset bits.

Configuration
REQ-026 SHALL, with SIG_RX_CHECK_EN defined, hold a 40-byte constant ROM "Luke Vassallo Tiny Tapeout 2023/03/24.\r\n" (0x4C first, 0x0A last) and compare each completed byte to ROM[byte_index].
REQ-027 SHALL, with SIG_RX_CHECK_EN defined, increment mismatch_cnt per differing byte and drive match=1 only in DONE with mismatch_cnt=0; FRAME_BYTES SHALL be 40.
REQ-028 SHALL, without SIG_RX_CHECK_EN, omit the ROM and comparator and tie match=0, mismatch_cnt=0.

Verification
REQ-029 SHALL cover: byte_ready=1, 8 en bits 0,1,0,0,1,1,0,0 -> byte_out=0x4C, byte_valid=1 one cycle after 8th bit, byte_index=1.
REQ-030 SHALL cover: byte_ready=0, 16 en bits 0x4C then 0x75 -> byte_out stays 0x4C, overrun=1; ld -> overrun=0, byte_valid=0.
REQ-031 SHALL cover: full 320-bit signature stream, byte_ready=1 (check build) -> frame_done pulse once at byte 40, byte_index=0, match=1, mismatch_cnt=0.
REQ-032 SHALL cover: same stream with byte 5 as 0x21 instead of 0x56 (check build) -> match=0, mismatch_cnt=1.
REQ-033 SHALL cover: ld and en asserted together after 3 bits -> bit discarded; next 8 bits form byte 0 at byte_index 0.
REQ-034 SHALL cover: reset asserted after 5 bits of byte 2 -> all outputs per REQ-024 immediately; next 8 bits yield byte_index=1.
